// File: rtl/logic_microoperation_driver_pkg.sv
// Shared types for the logic-microoperation driver: opcodes, FSM states, default widths
// and a reference evaluator of the logic unit's function.
package logic_microoperation_driver_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_OP_W  = 2;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOT = 2'b11
   } lu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } drv_state_e;

   // Operands are zero-extended to 32 bits; callers truncate back to their width.
   function automatic logic [31:0] lu_eval(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      unique case (lu_op_e'(op))
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = ~a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_microoperation_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x DW, with full/empty flags. Push when full and
// pop when empty are ignored.
module logic_microoperation_cmd_fifo
   import logic_microoperation_driver_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = DEF_OP_W + 2 * DEF_WIDTH
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/logic_microoperation_driver.sv
// Initiator for the logic-microoperation unit: queues {op,a,b}, issues one at a time,
// returns captured results. Optional result checker: LOGIC_MICROOPERATION_DRIVER_CHECK_EN.
module logic_microoperation_driver
   import logic_microoperation_driver_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned OP_W    = DEF_OP_W,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [OP_W-1:0]  lu_select,
   output logic [WIDTH-1:0] lu_a,
   output logic [WIDTH-1:0] lu_b,
   input  logic [WIDTH-1:0] lu_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OP_W-1:0]  rsp_op,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   output logic             mismatch
);

   localparam int unsigned CMD_W = OP_W + 2 * WIDTH;
   localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   drv_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]  lu_select_q, lu_select_d;
   logic [WIDTH-1:0] lu_a_q, lu_a_d;
   logic [WIDTH-1:0] lu_b_q, lu_b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [OP_W-1:0]  rsp_op_q, rsp_op_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [CMD_W-1:0] fifo_rdata;

   logic_microoperation_cmd_fifo #(
      .DEPTH (DEPTH),
      .DW    (CMD_W)
   ) u_cmd_fifo (
      .clock (clock),
      .reset (reset),
      .push  (cmd_valid),
      .pop   (fifo_pop),
      .wdata ({cmd_op, cmd_a, cmd_b}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;
   assign lu_select = lu_select_q;
   assign lu_a      = lu_a_q;
   assign lu_b      = lu_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_op    = rsp_op_q;
   assign rsp_data  = rsp_data_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lu_select_d = lu_select_q;
      lu_a_d      = lu_a_q;
      lu_b_d      = lu_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_op_d    = rsp_op_q;
      rsp_data_d  = rsp_data_q;
      fifo_pop    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop                         = 1'b1;
               {lu_select_d, lu_a_d, lu_b_d}    = fifo_rdata;
               cnt_d                            = CNT_W'(LATENCY);
               state_d                          = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rsp_data_d  = lu_data;
               rsp_op_d    = lu_select_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
               // Back-to-back issue: the next command is popped on the same edge the result leaves.
               if (!fifo_empty) begin
                  fifo_pop                      = 1'b1;
                  {lu_select_d, lu_a_d, lu_b_d} = fifo_rdata;
                  cnt_d                         = CNT_W'(LATENCY);
                  state_d                       = ST_WAIT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         lu_select_q <= '0;
         lu_a_q      <= '0;
         lu_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_op_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lu_select_q <= lu_select_d;
         lu_a_q      <= lu_a_d;
         lu_b_q      <= lu_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_op_q    <= rsp_op_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef LOGIC_MICROOPERATION_DRIVER_CHECK_EN
   logic             mismatch_q, mismatch_d;
   logic [WIDTH-1:0] expected;

   assign expected = WIDTH'(lu_eval(lu_select_q[1:0], 32'(lu_a_q), 32'(lu_b_q)));
   assign mismatch = mismatch_q;

   always_comb begin
      mismatch_d = mismatch_q;
      if ((state_q == ST_WAIT) && (cnt_q == '0) && (lu_data != expected)) begin
         mismatch_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_logic_microoperation_driver.sv
// Bench for logic_microoperation_driver: directed scenarios plus randomized traffic
// scored against a queue-based transaction model and a behavioural logic unit.
module tb_logic_microoperation_driver;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_a, cmd_b;
   logic [1:0] lu_select;
   logic [3:0] lu_a, lu_b;
   logic [3:0] lu_data = '0;
   logic       rsp_valid, rsp_ready;
   logic [1:0] rsp_op;
   logic [3:0] rsp_data;
   logic       busy, mismatch;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic       corrupt_xor = 1'b0;
   logic [5:0] exp_q [$];
   int         hs_q  [$];
   logic       hold_pend = 1'b0;
   logic [3:0] hold_data;

   always #5 clock = ~clock;

   logic_microoperation_driver #(
      .WIDTH   (4),
      .OP_W    (2),
      .DEPTH   (4),
      .LATENCY (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .lu_select (lu_select),
      .lu_a      (lu_a),
      .lu_b      (lu_b),
      .lu_data   (lu_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_op    (rsp_op),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .mismatch  (mismatch)
   );

   function automatic logic [3:0] model_f(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic bad_xor);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return bad_xor ? ~(a ^ b) : (a ^ b);
         default: return ~a;
      endcase
   endfunction

   // Logic unit stand-in: one register stage after lu_* settle.
   always @(posedge clock) lu_data <= model_f(lu_select, lu_a, lu_b, corrupt_xor);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic cycle(input logic cv, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic rr);
      logic [5:0] e;
      cmd_valid = cv;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      rsp_ready = rr;
      if (reset) begin
         if (hold_pend) begin
            check_eq("rsp_hold_valid", rsp_valid, 1);
            check_eq("rsp_hold_data", rsp_data, hold_data);
         end
         hold_pend = rsp_valid && !rr;
         hold_data = rsp_data;
         if (cv && cmd_ready) exp_q.push_back({op, model_f(op, a, b, corrupt_xor)});
         if (rsp_valid && rr) begin
            hs_q.push_back(cyc);
            check_eq("rsp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("rsp_op", rsp_op, e[5:4]);
               check_eq("rsp_data", rsp_data, e[3:0]);
            end
         end
      end else begin
         hold_pend = 1'b0;
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 200; k++) begin
         if (exp_q.size() == 0 && !busy && !rsp_valid) break;
         cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      end
      check_eq("drain_done", k < 200, 1);
   endtask

   initial begin
      int acc;
      logic [1:0] expect_mm;
`ifdef LOGIC_MICROOPERATION_DRIVER_CHECK_EN
      expect_mm = 2'd1;
`else
      expect_mm = 2'd0;
`endif
      reset = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 4'hf; cmd_b = 4'hf; rsp_ready = 1'b0;
      @(negedge clock);

      // 1: reset held with cmd_valid asserted
      cycle(1'b1, 2'd1, 4'hf, 4'hf, 1'b0);
      cycle(1'b1, 2'd2, 4'ha, 4'h5, 1'b0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_lu", {lu_select, lu_a, lu_b}, 0);
      check_eq("rst_mismatch", mismatch, 0);
      check_eq("rst_cmd_ready", cmd_ready, 1);
      reset = 1'b1;
      cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      check_eq("rst_busy", busy, 0);

      // 2: single OR, latency
      cycle(1'b1, 2'b01, 4'b0101, 4'b0011, 1'b1);
      cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      check_eq("single_lu", {lu_select, lu_a, lu_b}, {2'b01, 4'b0101, 4'b0011});
      check_eq("single_valid_e1", rsp_valid, 0);
      cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      check_eq("single_valid_e2", rsp_valid, 0);
      cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      check_eq("single_valid_e3", rsp_valid, 1);
      check_eq("single_data", rsp_data, 4'b0111);
      drain();
      check_eq("single_lu_hold", {lu_select, lu_a, lu_b}, {2'b01, 4'b0101, 4'b0011});

      // 3: backpressure, five accepted then full
      acc = 0;
      for (int k = 0; k < 20 && acc < 5; k++) begin
         if (cmd_ready) acc++;
         cycle(1'b1, 2'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      end
      check_eq("bp_accepted", acc, 5);
      check_eq("bp_full", cmd_ready, 0);
      check_eq("bp_rsp_valid", rsp_valid, 1);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 2'd3, 4'h9, 4'h9, 1'b0);
         check_eq("bp_still_full", cmd_ready, 0);
      end
      drain();
      check_eq("bp_queue_empty", exp_q.size(), 0);

      // 4: wrap with all four ops on fixed operands; steady-state spacing is LATENCY+2
      hs_q.delete();
      acc = 0;
      for (int k = 0; k < 100 && acc < 12; k++) begin
         if (cmd_ready) begin
            cycle(1'b1, 2'(acc % 4), 4'b1010, 4'b1100, 1'b1);
            acc++;
         end else begin
            cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
         end
      end
      check_eq("wrap_accepted", acc, 12);
      drain();
      check_eq("wrap_results", hs_q.size(), 12);
      for (int i = 1; i < hs_q.size(); i++) check_eq("wrap_spacing", hs_q[i] - hs_q[i-1], 3);

      // 5: reset while the command waits on the unit
      cycle(1'b1, 2'd0, 4'hf, 4'h3, 1'b1);
      cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      reset = 1'b0;
      cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      reset = 1'b1;
      exp_q.delete();
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_cmd_ready", cmd_ready, 1);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
         check_eq("midrst_no_rsp", rsp_valid, 0);
      end

      // 6: unit returns wrong XOR result; flag is sticky until reset
      corrupt_xor = 1'b1;
      cycle(1'b1, 2'd2, 4'b1010, 4'b1100, 1'b1);
      drain();
      corrupt_xor = 1'b0;
      check_eq("chk_flag", mismatch, expect_mm);
      cycle(1'b1, 2'd0, 4'b1010, 4'b1100, 1'b1);
      drain();
      check_eq("chk_sticky", mismatch, expect_mm);
      reset = 1'b0;
      cycle(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
      reset = 1'b1;
      check_eq("chk_cleared", mismatch, 0);

      // randomized traffic with random backpressure
      for (int k = 0; k < 400; k++) begin
         cycle(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom_range(0, 3) != 0));
      end
      drain();
      check_eq("rand_mismatch", mismatch, 0);
      check_eq("rand_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
